// File: rtl/wb_pkg.sv
// Shared constants for the writeback select stage: write-source select
// encodings and the load funct3 codes used by load alignment.
package wb_pkg;

  localparam int WB_SEL_ALU   = 0;
  localparam int WB_SEL_MEM   = 1;
  localparam int WB_SEL_PC4   = 2;
  localparam int WB_SEL_IMM   = 3;
  localparam int WB_SEL_PCIMM = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: shifts the loaded word down by the byte
// offset, then sign- or zero-extends according to the load funct3.
// Unknown funct3 codes return the raw, unshifted word.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_word >> {i_addr_lo, 3'b000};

  // Extend the addressed byte/half to XLEN according to the load type
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_data = w_shifted;
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select stage: picks the register-file write value from
// NUM_SRC packed sources, optionally aligns load data, and registers the
// result in a head register backed by a one-entry skid register.
// Build option: define WB_LOAD_ALIGN_EN to align/extend the memory source
// using mem_funct3/mem_addr_lo; otherwise the memory word passes raw.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic [2:0]              mem_funct3,
  input  logic [1:0]              mem_addr_lo,
  input  logic [4:0]              rd_addr,
  input  logic                    reg_write,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         rd_write_data,
  output logic [4:0]              rd_addr_o,
  output logic                    reg_write_o,
  output logic                    sel_err
);

  logic [XLEN-1:0] w_src_raw;
  logic            w_sel_ok;
  logic [XLEN-1:0] w_mem_word;
  logic [XLEN-1:0] w_mem_data;
  logic [XLEN-1:0] w_wb_data;
  logic            w_wb_we;
  logic            w_accept;
  logic            w_pop;

  logic            r_head_valid;
  logic [XLEN-1:0] r_head_data;
  logic [4:0]      r_head_rd;
  logic            r_head_we;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_data;
  logic [4:0]      r_skid_rd;
  logic            r_skid_we;
  logic            r_sel_err;

  // Decode the select index; an index with no matching source is illegal
  always_comb begin
    w_src_raw = '0;
    w_sel_ok  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        w_src_raw = src_data[k*XLEN +: XLEN];
        w_sel_ok  = 1'b1;
      end
    end
  end

  assign w_mem_word = src_data[WB_SEL_MEM*XLEN +: XLEN];

`ifdef WB_LOAD_ALIGN_EN
  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .i_word    (w_mem_word),
    .i_funct3  (mem_funct3),
    .i_addr_lo (mem_addr_lo),
    .o_data    (w_mem_data)
  );
`else
  // Load-type inputs have no effect without alignment
  logic w_unused_load;
  assign w_unused_load = ^{mem_funct3, mem_addr_lo};
  assign w_mem_data    = w_mem_word;
`endif

  assign w_wb_data = !w_sel_ok ? '0 :
                     (sel == SEL_W'(WB_SEL_MEM)) ? w_mem_data : w_src_raw;
  // x0 is never written, and an illegal select never writes
  assign w_wb_we   = reg_write && w_sel_ok && (rd_addr != 5'd0);

  // in_ready depends only on registered state, never on out_ready
  assign in_ready = !r_skid_valid;
  assign w_accept = in_valid && !r_skid_valid;
  assign w_pop    = r_head_valid && out_ready;

  // Head/skid storage: skid refills head on pop, otherwise the new entry
  // goes to head when it is free or popping, and to skid when head stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
      r_head_rd    <= '0;
      r_head_we    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_rd    <= '0;
      r_skid_we    <= 1'b0;
    end else if (w_pop && r_skid_valid) begin
      r_head_data  <= r_skid_data;
      r_head_rd    <= r_skid_rd;
      r_head_we    <= r_skid_we;
      r_skid_valid <= 1'b0;
    end else if (w_pop || !r_head_valid) begin
      r_head_valid <= w_accept;
      if (w_accept) begin
        r_head_data <= w_wb_data;
        r_head_rd   <= rd_addr;
        r_head_we   <= w_wb_we;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_wb_data;
      r_skid_rd    <= rd_addr;
      r_skid_we    <= w_wb_we;
    end
  end

  // Sticky illegal-select flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && !w_sel_ok) begin
      r_sel_err <= 1'b1;
    end
  end

  assign out_valid     = r_head_valid;
  assign rd_write_data = r_head_data;
  assign rd_addr_o     = r_head_rd;
  assign reg_write_o   = r_head_we;
  assign sel_err       = r_sel_err;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: a table of single-cycle
// transfers with out_ready high, then hand-written backpressure,
// illegal-select and mid-transfer reset sequences.
module tb_wb_select_stage;
  localparam int XLEN = 32;
  localparam int NSRC = 5;

  localparam logic [31:0] V_ALU   = 32'hA0A0_0001;
  localparam logic [31:0] V_PC4   = 32'h0000_1004;
  localparam logic [31:0] V_IMM   = 32'hFFFF_F800;
  localparam logic [31:0] V_PCIMM = 32'h1234_5678;
  localparam logic [31:0] V_LOAD  = 32'h8000_F0F1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NSRC*XLEN-1:0] src_data;
  logic [2:0]       sel;
  logic [2:0]       mem_funct3;
  logic [1:0]       mem_addr_lo;
  logic [4:0]       rd_addr;
  logic             reg_write;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  rd_write_data;
  logic [4:0]       rd_addr_o;
  logic             reg_write_o;
  logic             sel_err;

  int errors = 0;
  int checks = 0;

  wb_select_stage #(.XLEN(XLEN), .NUM_SRC(NSRC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .sel(sel), .mem_funct3(mem_funct3),
    .mem_addr_lo(mem_addr_lo), .rd_addr(rd_addr), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_write_data(rd_write_data), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] mem;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_src(input logic [31:0] mem);
    src_data = {V_PCIMM, V_IMM, V_PC4, mem, V_ALU};
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] mem, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd, input logic rw);
    sel = s; set_src(mem); mem_funct3 = f3; mem_addr_lo = off;
    rd_addr = rd; reg_write = rw; in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ld(input logic [31:0] aligned);
`ifdef WB_LOAD_ALIGN_EN
    return aligned;
`else
    return (aligned == aligned) ? V_LOAD : V_LOAD;
`endif
  endfunction

  initial begin
    vecs[0]  = '{3'd0, V_LOAD, 3'b010, 2'd0, 5'd1,  1'b1, V_ALU,   1'b1};
    vecs[1]  = '{3'd1, V_LOAD, 3'b010, 2'd0, 5'd2,  1'b1, V_LOAD,  1'b1};
    vecs[2]  = '{3'd2, V_LOAD, 3'b010, 2'd0, 5'd3,  1'b1, V_PC4,   1'b1};
    vecs[3]  = '{3'd3, V_LOAD, 3'b010, 2'd0, 5'd4,  1'b1, V_IMM,   1'b1};
    vecs[4]  = '{3'd4, V_LOAD, 3'b010, 2'd0, 5'd5,  1'b1, V_PCIMM, 1'b1};
    vecs[5]  = '{3'd1, V_LOAD, 3'b000, 2'd0, 5'd6,  1'b1, ld(32'hFFFF_FFF1), 1'b1};
    vecs[6]  = '{3'd1, V_LOAD, 3'b100, 2'd2, 5'd7,  1'b1, ld(32'h0000_0000), 1'b1};
    vecs[7]  = '{3'd1, V_LOAD, 3'b001, 2'd2, 5'd8,  1'b1, ld(32'hFFFF_8000), 1'b1};
    vecs[8]  = '{3'd1, V_LOAD, 3'b101, 2'd0, 5'd9,  1'b1, ld(32'h0000_F0F1), 1'b1};
    vecs[9]  = '{3'd0, V_LOAD, 3'b010, 2'd0, 5'd0,  1'b1, V_ALU,   1'b0};
    vecs[10] = '{3'd2, V_LOAD, 3'b010, 2'd0, 5'd10, 1'b0, V_PC4,   1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sel = '0; set_src(V_LOAD); mem_funct3 = '0; mem_addr_lo = '0;
    rd_addr = '0; reg_write = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", rd_write_data, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    chk("rst_we", 32'(reg_write_o), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream, one entry per cycle
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].sel, vecs[i].mem, vecs[i].f3, vecs[i].off, vecs[i].rd, vecs[i].rw);
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_data", i), rd_write_data, vecs[i].exp_data);
      chk($sformatf("v%0d_rd", i), 32'(rd_addr_o), 32'(vecs[i].rd));
      chk($sformatf("v%0d_we", i), 32'(reg_write_o), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("no_sel_err", 32'(sel_err), 32'd0);

    // Backpressure: A to head, B to skid, C waits
    out_ready = 1'b0;
    drive(3'd0, V_LOAD, 3'b010, 2'd0, 5'd11, 1'b1);
    step();
    chk("bp_a_head", 32'(rd_addr_o), 32'd11);
    chk("bp_a_in_ready", 32'(in_ready), 32'd1);
    drive(3'd2, V_LOAD, 3'b010, 2'd0, 5'd12, 1'b1);
    step();
    chk("bp_b_in_ready", 32'(in_ready), 32'd0);
    chk("bp_b_head_held", 32'(rd_addr_o), 32'd11);
    drive(3'd3, V_LOAD, 3'b010, 2'd0, 5'd13, 1'b1);
    step();
    chk("bp_c_blocked", 32'(in_ready), 32'd0);
    chk("bp_c_head_held", rd_write_data, V_ALU);
    out_ready = 1'b1;
    step();
    chk("bp_pop_b_rd", 32'(rd_addr_o), 32'd12);
    chk("bp_pop_b_data", rd_write_data, V_PC4);
    chk("bp_pop_b_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    chk("bp_c_rd", 32'(rd_addr_o), 32'd13);
    chk("bp_c_data", rd_write_data, V_IMM);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Illegal select and its sticky flag
    drive(3'd7, V_LOAD, 3'b010, 2'd0, 5'd5, 1'b1);
    step();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_data", rd_write_data, 32'd0);
    chk("ill_we", 32'(reg_write_o), 32'd0);
    chk("ill_rd", 32'(rd_addr_o), 32'd5);
    chk("ill_sel_err", 32'(sel_err), 32'd1);
    drive(3'd4, V_LOAD, 3'b010, 2'd0, 5'd6, 1'b1);
    step();
    in_valid = 1'b0;
    step(); step();
    chk("ill_sticky", 32'(sel_err), 32'd1);

    // Reset with head and skid both full
    out_ready = 1'b0;
    drive(3'd0, V_LOAD, 3'b010, 2'd0, 5'd20, 1'b1);
    step();
    drive(3'd2, V_LOAD, 3'b010, 2'd0, 5'd21, 1'b1);
    step();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", rd_write_data, 32'd0);
    chk("arst_rd", 32'(rd_addr_o), 32'd0);
    chk("arst_we", 32'(reg_write_o), 32'd0);
    chk("arst_sel_err", 32'(sel_err), 32'd0);
    step();
    @(negedge clk); rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    drive(3'd4, V_LOAD, 3'b010, 2'd0, 5'd31, 1'b1);
    step();
    in_valid = 1'b0;
    chk("post_rst_data", rd_write_data, V_PCIMM);
    chk("post_rst_we", 32'(reg_write_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised writeback stage for the RISC-V pipeline: selects the register-file write value from `NUM_SRC` candidate sources, optionally aligns and sign-extends load data, and registers the result behind a valid/ready handshake with a 2-entry skid buffer. Sits between the memory stage and the register file. Also exposes the head entry as a forwarding source for the hazard unit.

## Interface
- `XLEN`, 32, datapath width
- `NUM_SRC`, 5, number of candidate write sources (≥2)
- `SEL_W`, `$clog2(NUM_SRC)`, select width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  stage can accept an entry
- `src_data`  in  NUM_SRC*XLEN  packed sources; source k at bits [k*XLEN +: XLEN]
- `sel`  in  SEL_W  source index (encodings in package)
- `mem_funct3`  in  3  load type (LB/LH/LW/LBU/LHU)
- `mem_addr_lo`  in  2  load byte offset
- `rd_addr`  in  5  destination register
- `reg_write`  in  1  write request
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  register file / downstream accepts head
- `rd_write_data`  out  XLEN  selected write value
- `rd_addr_o`  out  5  destination register
- `reg_write_o`  out  1  write enable, qualified
- `sel_err`  out  1  sticky illegal-select flag

## Operation
- Accept when `in_valid && in_ready`; result computed combinationally from `src_data[sel]`, then registered.
- `sel ≥ NUM_SRC`: data forced to 0, `reg_write_o` forced 0, `sel_err` set; cleared only by reset.
- `rd_addr == 0`: `reg_write_o` forced 0; data still passed.
- Source `WB_SEL_MEM` goes through load alignment (see Configuration) before registering.
- Storage: head register (drives outputs) + skid register. `in_ready = !skid_valid`.
- Head pops when `out_valid && out_ready`. On pop, skid (if valid) moves to head; otherwise the accepted input (if any) fills head.
- Accept while head held (`out_valid && !out_ready`) → entry goes to skid.
- Simultaneous accept and pop with skid empty: new entry replaces head in the same edge.
- Order strictly preserved; no entry dropped or duplicated.
- Forwarding: hazard unit reads `rd_addr_o`/`rd_write_data`/`reg_write_o && out_valid` directly.

## Timing
- Latency: accept at edge N → `out_valid` high after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle with `out_ready` held high.
- `in_ready` is registered-state only (no combinational path from `out_ready`).
- Reset (async, any time, including mid-transfer): `out_valid`=0, `rd_write_data`=0, `rd_addr_o`=0, `reg_write_o`=0, `sel_err`=0, skid empty, `in_ready`=1 on first cycle after deassertion. In-flight entries discarded.

## Configuration
- `WB_LOAD_ALIGN_EN` defined: memory source shifted right by `8*mem_addr_lo`; LB/LH sign-extend byte/half to XLEN, LBU/LHU zero-extend, LW passes; unknown funct3 passes raw word.
- Undefined: memory source passed raw; `mem_funct3`/`mem_addr_lo` ignored (ports remain).

## Structure
- Package `wb_pkg`: select encodings `WB_SEL_ALU`=0, `WB_SEL_MEM`=1, `WB_SEL_PC4`=2, `WB_SEL_IMM`=3, `WB_SEL_PCIMM`=4; load funct3 constants `F3_LB`=000, `F3_LH`=001, `F3_LW`=010, `F3_LBU`=100, `F3_LHU`=101.
- One sub-module: `wb_load_align` (combinational; instantiated only under `WB_LOAD_ALIGN_EN`).

## Test plan
- Reset then sel=0..4 with distinct sources, `out_ready`=1 → one cycle later each source value appears in order, 1/cycle.
- `sel`=1, word 0x8000_F0F1, LB offset 0 → 0xFFFF_FFF1; LBU offset 2 → 0x0000_0000; LH offset 2 → 0xFFFF_8000 (with macro); without macro → 0x8000_F0F1.
- Hold `out_ready`=0, push 3 entries → first two stored, `in_ready`=0 after second; release → entries drain in order, third accepted.
- `sel`=7, rd=5, reg_write=1 → data 0, `reg_write_o`=0, `sel_err`=1 persisting until reset.
- rd=0, reg_write=1 → `reg_write_o`=0, data unchanged.
- Assert `rst` with both registers full → all outputs 0 immediately, `in_ready`=1 after release.
